// File: rtl/lc3_loader_pkg.sv
// Shared types and constants for the LC-3 object-stream program loader.
package lc3_loader_pkg;

    localparam int OBJ_HDR_WORDS = 2;
    localparam int WORD_W        = 16;

    // Header states come in HI/LO pairs, so the first data state sits just
    // past the header byte states.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ORIG_HI,
        ST_ORIG_LO,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI = 4'(1 + 2 * OBJ_HDR_WORDS),
        ST_DATA_LO,
        ST_W_SETUP,
        ST_W_PULSE,
        ST_W_HOLD,
        ST_V_WAIT,
        ST_V_CHECK,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    // True for the states in which the loader takes a byte from the host link.
    function automatic logic accepts_byte(input loader_state_e st);
        logic r;
        case (st)
            ST_ORIG_HI, ST_ORIG_LO,
            ST_LEN_HI,  ST_LEN_LO,
            ST_DATA_HI, ST_DATA_LO: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lc3_program_loader_b2w.sv
// Byte-pair assembler: big-endian HI byte then LO byte, handshake driven by
// the loader's accept window.
module lc3_byte_to_word
    import lc3_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              phase_lo
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    logic       fire_s;

    assign in_ready   = accept;
    assign fire_s     = in_valid && accept;
    assign phase_lo   = phase_q;
    assign word       = {hi_q, in_data};
    assign word_valid = fire_s && phase_q;

    // Next phase and captured HI byte.
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clear) begin
            phase_d = 1'b0;
        end else if (fire_s) begin
            if (phase_q) begin
                phase_d = 1'b0;
            end else begin
                phase_d = 1'b1;
                hi_d    = in_data;
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: rtl/lc3_program_loader.sv
// LC-3 program loader: parses an object byte stream and writes it through the
// direct memory port, optionally reading each word back to verify it.
module lc3_program_loader
    import lc3_loader_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int VERIFY   = 1,
    parameter int PULSE_W  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] address_in_direct,
    output logic [WORD_W-1:0] data_in_direct,
    output logic              clk_direct,
    input  logic [WORD_W-1:0] mem_out_direct,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] entry_pc,
    output logic [WORD_W-1:0] words_written,
    output logic [WORD_W-1:0] err_addr
);

    localparam logic [15:0] PULSE_LAST = 16'((PULSE_W > 0) ? PULSE_W - 1 : 0);
    localparam logic [15:0] READ_LAST  = 16'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    loader_state_e     state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0] remaining_q, remaining_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] entry_q, entry_d;
    logic [WORD_W-1:0] words_q, words_d;
    logic [WORD_W-1:0] err_addr_q, err_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              in_ready_q, in_ready_d;
    logic              clk_dir_q, clk_dir_d;

    logic              asm_clear_s;
    logic              asm_ready_s;
    logic              word_valid_s;
    logic [WORD_W-1:0] word_s;
    logic              phase_lo_s;
    logic              hi_fire_s;

    lc3_byte_to_word u_b2w (
        .clk        (clk),
        .rst        (reset),
        .clear      (asm_clear_s),
        .accept     (in_ready_q),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (asm_ready_s),
        .word_valid (word_valid_s),
        .word       (word_s),
        .phase_lo   (phase_lo_s)
    );

    assign hi_fire_s = in_valid && in_ready_q && !phase_lo_s;

    // Loader sequencing: header parse, write strobe, verify and bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        data_d      = data_q;
        entry_d     = entry_q;
        words_d     = words_q;
        err_addr_d  = err_addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        asm_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ORIG_HI;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    words_d     = 16'h0000;
                    err_addr_d  = 16'h0000;
                    busy_d      = 1'b1;
                    asm_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ORIG_HI: begin
                if (hi_fire_s) state_d = ST_ORIG_LO;
                else           state_d = ST_ORIG_HI;
            end
            ST_ORIG_LO: begin
                if (word_valid_s) begin
                    entry_d = word_s;
                    addr_d  = word_s;
                    state_d = ST_LEN_HI;
                end else begin
                    state_d = ST_ORIG_LO;
                end
            end
            ST_LEN_HI: begin
                if (hi_fire_s) state_d = ST_LEN_LO;
                else           state_d = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (word_valid_s) begin
                    remaining_d = word_s;
                    state_d     = (word_s == 16'h0000) ? ST_DONE : ST_DATA_HI;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_DATA_HI: begin
                if (hi_fire_s) state_d = ST_DATA_LO;
                else           state_d = ST_DATA_HI;
            end
            ST_DATA_LO: begin
                if (word_valid_s) begin
                    data_d  = word_s;
                    state_d = ST_W_SETUP;
                end else begin
                    state_d = ST_DATA_LO;
                end
            end
            ST_W_SETUP: begin
                cnt_d   = 16'h0000;
                state_d = ST_W_PULSE;
            end
            ST_W_PULSE: begin
                if (cnt_q >= PULSE_LAST) begin
                    state_d = ST_W_HOLD;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            ST_W_HOLD: begin
                words_d = words_q + 16'h0001;
                cnt_d   = 16'h0000;
                if (VERIFY != 0) state_d = (READ_LAT > 0) ? ST_V_WAIT : ST_V_CHECK;
                else             state_d = ST_NEXT;
            end
            ST_V_WAIT: begin
                if (cnt_q >= READ_LAST) begin
                    state_d = ST_V_CHECK;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            ST_V_CHECK: begin
                if (mem_out_direct != data_q) begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = ST_ERROR;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                addr_d      = addr_q + 16'h0001;
                remaining_d = remaining_q - 16'h0001;
                state_d     = (remaining_q == 16'h0001) ? ST_DONE : ST_DATA_HI;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = accepts_byte(state_d);
        clk_dir_d  = (state_d == ST_W_PULSE);
    end

    // Loader state and registered outputs; clk_direct comes straight off a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'h0000;
            remaining_q <= 16'h0000;
            addr_q      <= 16'h0000;
            data_q      <= 16'h0000;
            entry_q     <= 16'h0000;
            words_q     <= 16'h0000;
            err_addr_q  <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            clk_dir_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            entry_q     <= entry_d;
            words_q     <= words_d;
            err_addr_q  <= err_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            in_ready_q  <= in_ready_d;
            clk_dir_q   <= clk_dir_d;
        end
    end

    assign in_ready          = asm_ready_s;
    assign address_in_direct = addr_q;
    assign data_in_direct    = data_q;
    assign clk_direct        = clk_dir_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign entry_pc          = entry_q;
    assign words_written     = words_q;
    assign err_addr          = err_addr_q;

endmodule

// File: tb/tb_lc3_program_loader.sv
// Bench for lc3_program_loader: object-stream model, memory model on the
// direct port, and a write monitor checking every strobe against the model.
module tb_lc3_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, clk_direct, busy, done, error;
    logic [15:0] address_in_direct, data_in_direct, entry_pc, words_written, err_addr;
    logic [15:0] mem_out_direct = 16'h0000;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [0:65535];
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = 16'h0000;

    logic [31:0] exp_wr[$];
    int          wr_idx = 0;
    logic [7:0]  stream[$];

    logic        exp_done, exp_error;
    logic [15:0] exp_entry, exp_ww, exp_err_addr;

    always #5 clk = ~clk;

    lc3_program_loader #(.READ_LAT(1), .VERIFY(1), .PULSE_W(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .address_in_direct (address_in_direct),
        .data_in_direct    (data_in_direct),
        .clk_direct        (clk_direct),
        .mem_out_direct    (mem_out_direct),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .entry_pc          (entry_pc),
        .words_written     (words_written),
        .err_addr          (err_addr)
    );

    // Direct-port read path with one cycle of latency.
    always @(posedge clk) mem_out_direct <= mem[address_in_direct];

    // Write monitor: commits the write into the memory model and checks it.
    always @(posedge clk_direct) begin
        logic [15:0] flip;
        flip = (corrupt_en && address_in_direct == corrupt_addr) ? 16'h0001 : 16'h0000;
        mem[address_in_direct] = data_in_direct ^ flip;
        tests++;
        if (wr_idx >= exp_wr.size()) begin
            fails++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", address_in_direct, data_in_direct);
        end else if ({address_in_direct, data_in_direct} !== exp_wr[wr_idx]) begin
            fails++;
            $display("FAIL write_%0d: addr/data=%h, required %h", wr_idx, {address_in_direct, data_in_direct}, exp_wr[wr_idx]);
        end
        wr_idx++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Model of one load: the writes the stream calls for and the final status.
    task automatic build_model(input int max_writes);
        logic [15:0] org, len, a, w;
        org = {stream[0], stream[1]};
        len = {stream[2], stream[3]};
        exp_entry = org; exp_done = 1'b1; exp_error = 1'b0;
        exp_ww = 16'h0000; exp_err_addr = 16'h0000;
        for (int i = 0; i < int'(len) && i < max_writes; i++) begin
            a = org + 16'(i);
            w = {stream[4 + 2 * i], stream[5 + 2 * i]};
            exp_wr.push_back({a, w});
            exp_ww++;
            if (corrupt_en && a == corrupt_addr) begin
                exp_error = 1'b1; exp_done = 1'b0; exp_err_addr = a;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends the first nbytes of the stream; optional random gaps and a stray start.
    task automatic send_stream(input int nbytes, input bit throttle, input int start_at);
        int n;
        for (int k = 0; k < nbytes; k++) begin
            if (k == start_at) pulse_start();
            if (throttle) repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            in_data = stream[k];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
            if (n >= 200) begin
                in_valid = 1'b0;
                chk("byte_timeout", 32'(k), 32'hFFFF_FFFF);
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", 32'(n < 500), 32'h1);
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_done"},     32'(done),          32'(exp_done));
        chk({tag, "_error"},    32'(error),         32'(exp_error));
        chk({tag, "_busy"},     32'(busy),          32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready),      32'h0);
        chk({tag, "_entry"},    32'(entry_pc),      32'(exp_entry));
        chk({tag, "_words"},    32'(words_written), 32'(exp_ww));
        chk({tag, "_err_addr"}, 32'(err_addr),      32'(exp_err_addr));
        chk({tag, "_nwrites"},  32'(wr_idx),        32'(exp_wr.size()));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready),          32'h0);
        chk({tag, "_clk_dir"},  32'(clk_direct),        32'h0);
        chk({tag, "_busy"},     32'(busy),              32'h0);
        chk({tag, "_done"},     32'(done),              32'h0);
        chk({tag, "_error"},    32'(error),             32'h0);
        chk({tag, "_addr"},     32'(address_in_direct), 32'h0);
        chk({tag, "_data"},     32'(data_in_direct),    32'h0);
        chk({tag, "_entry"},    32'(entry_pc),          32'h0);
        chk({tag, "_words"},    32'(words_written),     32'h0);
        chk({tag, "_err_addr"}, 32'(err_addr),          32'h0);
    endtask

    initial begin
        #1;
        check_reset("rst");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Two-word load with verify.
        stream = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h21, 8'h0F, 8'hFE};
        build_model(65536);
        pulse_start();
        send_stream(stream.size(), 1'b0, -1);
        wait_idle();
        check_end("s1");
        chk("s1_entry_lit", 32'(entry_pc),      32'h3000);
        chk("s1_words_lit", 32'(words_written), 32'h2);
        chk("s1_mem3000",   32'(mem[16'h3000]), 32'h1221);
        chk("s1_mem3001",   32'(mem[16'h3001]), 32'h0FFE);
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (3) begin
            @(posedge clk); #1;
            chk("s1_extra_byte_ready", 32'(in_ready), 32'h0);
        end
        in_valid = 1'b0;
        chk("s1_done_sticky", 32'(done), 32'h1);

        // Zero-length load: no strobe, done one cycle after the length byte.
        stream = '{8'h30, 8'h00, 8'h00, 8'h00};
        build_model(65536);
        pulse_start();
        send_stream(stream.size(), 1'b0, -1);
        chk("s2_done_early", 32'(done), 32'h0);
        @(posedge clk); #1;
        chk("s2_done_lit", 32'(done), 32'h1);
        wait_idle();
        check_end("s2");

        // Address wrap 0xFFFF -> 0x0000.
        stream = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hAA, 8'h55, 8'h55};
        build_model(65536);
        pulse_start();
        send_stream(stream.size(), 1'b0, -1);
        wait_idle();
        check_end("s3");
        chk("s3_memFFFF", 32'(mem[16'hFFFF]), 32'hAAAA);
        chk("s3_mem0000", 32'(mem[16'h0000]), 32'h5555);

        // Verify failure on the second word.
        corrupt_en = 1'b1; corrupt_addr = 16'h3001;
        stream = '{8'h30, 8'h00, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        build_model(65536);
        pulse_start();
        send_stream(8, 1'b0, -1);
        wait_idle();
        check_end("s4");
        chk("s4_err_lit",   32'(err_addr),      32'h3001);
        chk("s4_words_lit", 32'(words_written), 32'h2);
        chk("s4_mem3001",   32'(mem[16'h3001]), 32'h2223);
        in_valid = 1'b1; in_data = 8'h33;
        @(posedge clk); #1;
        chk("s4_extra_byte_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        corrupt_en = 1'b0;

        // Reset asserted while the second word's strobe is high.
        stream = '{8'h40, 8'h00, 8'h00, 8'h03, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h77, 8'h77};
        build_model(2);
        pulse_start();
        send_stream(8, 1'b0, -1);
        @(posedge clk); #2;
        chk("s5_pulse_high", 32'(clk_direct), 32'h1);
        reset = 1'b1;
        #1;
        check_reset("s5");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("s5_nwrites", 32'(wr_idx), 32'(exp_wr.size()));
        chk("s5_idle_ready", 32'(in_ready), 32'h0);

        // Reload after reset with throttled bytes and a stray start while busy.
        stream = '{8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h21, 8'h0F, 8'hFE};
        build_model(65536);
        pulse_start();
        send_stream(stream.size(), 1'b1, 3);
        wait_idle();
        check_end("s6");
        chk("s6_mem3001", 32'(mem[16'h3001]), 32'h0FFE);
        repeat (3) @(posedge clk);
        #1;
        chk("s6_stray_start", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
